// File: rtl/signed_divider.sv
// Sequential signed divider: 2*DW-bit dividend / DW-bit divisor -> {remainder, quotient}; restoring, one bit per clock.
// Latency: DW+2 edges from accepting start to valid (2 edges for divide-by-zero / overflow).
// No backpressure: start is only honoured in IDLE/DONE; result held until the next accepted start.
module signed_divider #(
    parameter int DW = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DW-1:0]     opera1,
    input  logic [2*DW-1:0]   opera2,
    output logic [2*DW-1:0]   result,
    output logic              valid,
    output logic              busy,
    output logic              div_by_zero,
    output logic              overflow
);

    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] QMIN_MAG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]   div_q;
    logic [2*DW-1:0] dvd_q;
    logic [DW-1:0]   dmag;
    logic [DW-1:0]   rem;
    logic [DW-1:0]   quo;
    logic            qneg;
    logic            rneg;
    logic            pend_dz;
    logic            pend_ovf;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic [DW-1:0]   div_abs;
    logic [2*DW-1:0] dvd_abs;
    logic            is_dz;
    logic            pre_ovf;
    logic [DW:0]     trial;
    logic [DW:0]     diff;
    logic            q_bit;
    logic [DW-1:0]   q_signed;
    logic [DW-1:0]   r_signed;
    logic            range_ovf;

    always_comb begin
        accept    = start && ((state == IDLE) || (state == DONE));
        div_abs   = div_q[DW-1] ? -div_q : div_q;
        dvd_abs   = dvd_q[2*DW-1] ? -dvd_q : dvd_q;
        is_dz     = (div_q == '0);
        // Upper half >= divisor means the quotient needs more than DW bits.
        pre_ovf   = (dvd_abs[2*DW-1:DW] >= div_abs);
        // rem < dmag <= 2^(DW-1), so the shifted trial fits in DW bits and diff's MSB is a clean sign.
        trial     = {rem, quo[DW-1]};
        diff      = trial - {1'b0, dmag};
        q_bit     = ~diff[DW];
        q_signed  = qneg ? -quo : quo;
        r_signed  = rneg ? -rem : rem;
        range_ovf = qneg ? (quo > QMIN_MAG) : (quo >= QMIN_MAG);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = PREP;
            // Error cases still pass through FIX so flags and valid appear together.
            PREP: state_nxt = (is_dz || pre_ovf) ? FIX : CALC;
            CALC: if (cnt == CW'(DW-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (start) state_nxt = PREP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            dvd_q       <= '0;
            dmag        <= '0;
            rem         <= '0;
            quo         <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            pend_dz     <= 1'b0;
            pend_ovf    <= 1'b0;
            cnt         <= '0;
            result      <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                div_q       <= opera1;
                dvd_q       <= opera2;
                valid       <= 1'b0;
                busy        <= 1'b1;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
            case (state)
                PREP: begin
                    dmag     <= div_abs;
                    rem      <= dvd_abs[2*DW-1:DW];
                    quo      <= dvd_abs[DW-1:0];
                    qneg     <= div_q[DW-1] ^ dvd_q[2*DW-1];
                    rneg     <= dvd_q[2*DW-1];
                    pend_dz  <= is_dz;
                    pend_ovf <= !is_dz && pre_ovf;
                    cnt      <= '0;
                end
                CALC: begin
                    rem <= q_bit ? diff[DW-1:0] : trial[DW-1:0];
                    quo <= {quo[DW-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    if (pend_dz) begin
                        div_by_zero <= 1'b1;
                        result      <= '0;
                    end else if (pend_ovf || range_ovf) begin
                        overflow <= 1'b1;
                        result   <= '0;
                    end else begin
                        result <= {r_signed, q_signed};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// Directed and randomized self-checking bench for signed_divider (DW=32).
module tb_signed_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] opera1;
    logic [63:0] opera2;
    logic [63:0] result;
    logic        valid;
    logic        busy;
    logic        div_by_zero;
    logic        overflow;

    int tests    = 0;
    int failures = 0;

    signed_divider #(.DW(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .opera1      (opera1),
        .opera2      (opera2),
        .result      (result),
        .valid       (valid),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] d, input logic [63:0] n);
        opera1 = d;
        opera2 = n;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("accept_valid_busy", {valid, busy}, 2'b01);
    endtask

    task automatic wait_valid(inout int lat);
        while (!valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    // Reference: 64-bit signed division, truncating toward zero; returns {dz, ovf, rem, quo}.
    function automatic logic [65:0] model(input logic [31:0] d, input logic [63:0] n);
        logic signed [63:0] sn;
        logic signed [63:0] sd;
        logic signed [63:0] q64;
        logic signed [63:0] r64;
        sn = n;
        sd = {{32{d[31]}}, d};
        if (d == 32'd0) return {2'b10, 64'd0};
        if (n == 64'h8000_0000_0000_0000 && d == 32'hFFFF_FFFF) return {2'b01, 64'd0};
        q64 = sn / sd;
        r64 = sn % sd;
        if (q64 > 64'sd2147483647 || q64 < -64'sd2147483648) return {2'b01, 64'd0};
        return {2'b00, r64[31:0], q64[31:0]};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] d, input logic [63:0] n,
                          input int exp_lat, input logic [65:0] exp_res);
        int lat;
        lat = 0;
        accept(d, n);
        wait_valid(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, {busy, div_by_zero, overflow, result}, {1'b0, exp_res});
    endtask

    initial begin
        int lat;
        logic [63:0] rn;
        logic [31:0] rd;

        reset  = 1'b0;
        start  = 1'b0;
        opera1 = '0;
        opera2 = '0;
        #3;
        check("reset_outputs", {result, valid, busy, div_by_zero, overflow}, 68'd0);
        step();
        reset = 1'b1;
        step();

        run_op("basic_32_2", 32'd2, 64'd32, 34, {2'b00, 32'd0, 32'd16});
        run_op("s_32_m2",  32'hFFFF_FFFE, 64'd32,                  34, {2'b00, 32'd0,         32'hFFFF_FFF0});
        run_op("s_m32_2",  32'd2,         64'hFFFF_FFFF_FFFF_FFE0, 34, {2'b00, 32'd0,         32'hFFFF_FFF0});
        run_op("s_m32_m2", 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFE0, 34, {2'b00, 32'd0,         32'd16});
        run_op("s_m33_2",  32'd2,         64'hFFFF_FFFF_FFFF_FFDF, 34, {2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFF0});
        run_op("s_33_m2",  32'hFFFF_FFFE, 64'd33,                  34, {2'b00, 32'd1,         32'hFFFF_FFF0});

        run_op("div_zero",    32'd0, 64'd100,                  2,  {2'b10, 64'd0});
        run_op("ovf_pre",     32'd1, 64'h0000_0100_0000_0000,  2,  {2'b01, 64'd0});
        run_op("ovf_fix",     32'd1, 64'h0000_0000_8000_0000,  34, {2'b01, 64'd0});
        run_op("ovf_min_m1",  32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 34, {2'b01, 64'd0});
        run_op("min_by_1",    32'd1, 64'hFFFF_FFFF_8000_0000,  34, {2'b00, 32'd0, 32'h8000_0000});

        // start and operand activity while busy must not disturb 100/7.
        accept(32'd7, 64'd100);
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            lat++;
        end
        for (int i = 0; i < 6; i++) begin
            start  = ~start;
            opera1 = $urandom;
            opera2 = {$urandom, $urandom};
            step();
            lat++;
        end
        start = 1'b0;
        wait_valid(lat);
        check("ignore_start_lat", lat, 34);
        check("ignore_start_res", {div_by_zero, overflow, result}, {2'b00, 32'd2, 32'd14});

        // Asynchronous reset in the middle of CALC.
        accept(32'd3, 64'd1000);
        for (int i = 0; i < 10; i++) step();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {result, valid, busy, div_by_zero, overflow}, 68'd0);
        step();
        reset = 1'b1;
        step();
        run_op("after_reset", 32'd3, 64'd1000, 34, {2'b00, 32'd1, 32'd333});

        // Back-to-back: new start on the first DONE cycle.
        run_op("b2b_first", 32'd4, 64'd45, 34, {2'b00, 32'd1, 32'd11});
        run_op("b2b_second", 32'd4, 64'hFFFF_FFFF_FFFF_FFD3, 34,
               {2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFF5});

        for (int i = 0; i < 1000; i++) begin
            rn = {$urandom, $urandom};
            rn = $signed(rn) >>> $urandom_range(0, 63);
            rd = $urandom;
            rd = $signed(rd) >>> $urandom_range(0, 31);
            accept(rd, rn);
            lat = 0;
            wait_valid(lat);
            check("sweep", {valid, div_by_zero, overflow, result}, {1'b1, model(rd, rn)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
